// File: rtl/pong_game_engine_if.sv
// Signal bundle between the Pong game engine and its neighbours: frame pacing,
// player controls in, registered positions/scores/state out to the VGA generator.
interface pong_game_engine_if;
   logic       frame_tick;
   logic       l_up;
   logic       l_down;
   logic       r_up;
   logic       r_down;
   logic       restart;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic [9:0] l_paddle_y;
   logic [9:0] r_paddle_y;
   logic [3:0] score_l;
   logic [3:0] score_r;
   logic [1:0] game_state;

   modport master (
      output frame_tick, l_up, l_down, r_up, r_down, restart,
      input  ball_x, ball_y, l_paddle_y, r_paddle_y, score_l, score_r, game_state
   );

   modport slave (
      input  frame_tick, l_up, l_down, r_up, r_down, restart,
      output ball_x, ball_y, l_paddle_y, r_paddle_y, score_l, score_r, game_state
   );
endinterface

// File: rtl/pong_game_engine.sv
// Pong game-state engine: once per frame moves paddles and ball, resolves collisions,
// keeps score and sequences SERVE/PLAY/GAME_OVER. Optional PONG_SPEEDUP_EN adds ball speed-up on paddle hits.
module pong_game_engine #(
   parameter int SCREEN_W     = 640,
   parameter int SCREEN_H     = 480,
   parameter int PADDLE_W     = 10,
   parameter int PADDLE_H     = 60,
   parameter int PADDLE_X     = 20,
   parameter int BALL_SIZE    = 8,
   parameter int BALL_SPEED   = 4,
   parameter int PADDLE_SPEED = 4,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_SCORE    = 9
) (
   input logic               clk,
   input logic               rst_n,
   pong_game_engine_if.slave bus
);

   localparam logic [1:0] ST_SERVE = 2'd0;
   localparam logic [1:0] ST_PLAY  = 2'd1;
   localparam logic [1:0] ST_OVER  = 2'd2;

   localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
   localparam int SPD_W = $clog2(2 * BALL_SPEED + 1);

   localparam logic [9:0]  BALL_CX  = 10'((SCREEN_W - BALL_SIZE) / 2);
   localparam logic [9:0]  BALL_CY  = 10'((SCREEN_H - BALL_SIZE) / 2);
   localparam logic [9:0]  PAD_C    = 10'((SCREEN_H - PADDLE_H) / 2);
   localparam logic [9:0]  PAD_MAX  = 10'(SCREEN_H - PADDLE_H);
   localparam logic [9:0]  Y_MAX    = 10'(SCREEN_H - BALL_SIZE);
   localparam logic [10:0] X_MAX    = 11'(SCREEN_W - BALL_SIZE);
   localparam logic [9:0]  L_FACE   = 10'(PADDLE_X + PADDLE_W);
   localparam logic [10:0] R_FACE   = 11'(SCREEN_W - PADDLE_X - PADDLE_W);
   localparam logic [9:0]  R_STOP   = 10'(SCREEN_W - PADDLE_X - PADDLE_W - BALL_SIZE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [9:0]       ball_x_q, ball_x_d;
   logic [9:0]       ball_y_q, ball_y_d;
   logic [9:0]       l_pad_q, l_pad_d;
   logic [9:0]       r_pad_q, r_pad_d;
   logic [3:0]       score_l_q, score_l_d;
   logic [3:0]       score_r_q, score_r_d;
   logic             dir_x_q, dir_x_d;   // 1 = right
   logic             dir_y_q, dir_y_d;   // 1 = down

   logic             score_l_evt;
   logic             score_r_evt;
   logic [SPD_W-1:0] cur_spd_x;
   logic [SPD_W-1:0] cur_spd_y;

`ifdef PONG_SPEEDUP_EN
   localparam logic [SPD_W-1:0] SPD_MAX = SPD_W'(2 * BALL_SPEED);
   logic [SPD_W-1:0] spd_x_q, spd_x_d;
   logic [SPD_W-1:0] spd_y_q, spd_y_d;
   logic             paddle_hit;
   assign cur_spd_x = spd_x_q;
   assign cur_spd_y = spd_y_q;
`else
   assign cur_spd_x = SPD_W'(BALL_SPEED);
   assign cur_spd_y = SPD_W'(BALL_SPEED);
`endif

   function automatic logic [9:0] paddle_next(input logic [9:0] y, input logic up, input logic dn);
      logic [9:0] res;
      if (up && !dn) begin
         if (y < 10'(PADDLE_SPEED)) begin
            res = 10'd0;
         end else begin
            res = y - 10'(PADDLE_SPEED);
         end
      end else if (dn && !up) begin
         if ({1'b0, y} + 11'(PADDLE_SPEED) > {1'b0, PAD_MAX}) begin
            res = PAD_MAX;
         end else begin
            res = y + 10'(PADDLE_SPEED);
         end
      end else begin
         res = y;
      end
      return res;
   endfunction

   function automatic logic overlaps(input logic [9:0] by, input logic [9:0] py);
      return (({1'b0, by} + 11'(BALL_SIZE)) > {1'b0, py}) &&
             ({1'b0, by} < ({1'b0, py} + 11'(PADDLE_H)));
   endfunction

   // Next-state computation for the whole game, evaluated every cycle, committed on clk.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ball_x_d    = ball_x_q;
      ball_y_d    = ball_y_q;
      l_pad_d     = l_pad_q;
      r_pad_d     = r_pad_q;
      score_l_d   = score_l_q;
      score_r_d   = score_r_q;
      dir_x_d     = dir_x_q;
      dir_y_d     = dir_y_q;
      score_l_evt = 1'b0;
      score_r_evt = 1'b0;
`ifdef PONG_SPEEDUP_EN
      spd_x_d     = spd_x_q;
      spd_y_d     = spd_y_q;
      paddle_hit  = 1'b0;
`endif

      case (state_q)
         ST_SERVE: begin
            if (bus.frame_tick) begin
               l_pad_d  = paddle_next(l_pad_q, bus.l_up, bus.l_down);
               r_pad_d  = paddle_next(r_pad_q, bus.r_up, bus.r_down);
               ball_x_d = BALL_CX;
               ball_y_d = BALL_CY;
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = {CNT_W{1'b0}};
                  state_d = ST_PLAY;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end

         ST_PLAY: begin
            if (bus.frame_tick) begin
               l_pad_d = paddle_next(l_pad_q, bus.l_up, bus.l_down);
               r_pad_d = paddle_next(r_pad_q, bus.r_up, bus.r_down);

               // Vertical: sums rather than differences keep the wall test wrap-free.
               if (!dir_y_q) begin
                  if (ball_y_q <= 10'(cur_spd_y)) begin
                     ball_y_d = 10'd0;
                     dir_y_d  = 1'b1;
                  end else begin
                     ball_y_d = ball_y_q - 10'(cur_spd_y);
                  end
               end else begin
                  if ({1'b0, ball_y_q} + 11'(cur_spd_y) >= {1'b0, Y_MAX}) begin
                     ball_y_d = Y_MAX;
                     dir_y_d  = 1'b0;
                  end else begin
                     ball_y_d = ball_y_q + 10'(cur_spd_y);
                  end
               end

               // Horizontal: a paddle only catches a ball that would cross its face this frame.
               if (!dir_x_q) begin
                  if ((ball_x_q >= L_FACE) &&
                      ({1'b0, ball_x_q} < ({1'b0, L_FACE} + 11'(cur_spd_x))) &&
                      overlaps(ball_y_q, l_pad_q)) begin
                     ball_x_d = L_FACE;
                     dir_x_d  = 1'b1;
`ifdef PONG_SPEEDUP_EN
                     paddle_hit = 1'b1;
`endif
                  end else if (ball_x_q < 10'(cur_spd_x)) begin
                     score_r_evt = 1'b1;
                  end else begin
                     ball_x_d = ball_x_q - 10'(cur_spd_x);
                  end
               end else begin
                  if (({1'b0, ball_x_q} + 11'(BALL_SIZE) <= R_FACE) &&
                      ({1'b0, ball_x_q} + 11'(BALL_SIZE) + 11'(cur_spd_x) > R_FACE) &&
                      overlaps(ball_y_q, r_pad_q)) begin
                     ball_x_d = R_STOP;
                     dir_x_d  = 1'b0;
`ifdef PONG_SPEEDUP_EN
                     paddle_hit = 1'b1;
`endif
                  end else if ({1'b0, ball_x_q} + 11'(cur_spd_x) >= X_MAX) begin
                     score_l_evt = 1'b1;
                  end else begin
                     ball_x_d = ball_x_q + 10'(cur_spd_x);
                  end
               end

               // Point scored: serve toward whoever conceded, vertical direction kept.
               if (score_l_evt || score_r_evt) begin
                  ball_x_d = BALL_CX;
                  ball_y_d = BALL_CY;
                  dir_y_d  = dir_y_q;
                  dir_x_d  = score_l_evt;
                  cnt_d    = {CNT_W{1'b0}};
                  if (score_l_evt) begin
                     score_l_d = score_l_q + 4'd1;
                  end else begin
                     score_r_d = score_r_q + 4'd1;
                  end
                  if ((score_l_evt && (score_l_q + 4'd1 == 4'(WIN_SCORE))) ||
                      (score_r_evt && (score_r_q + 4'd1 == 4'(WIN_SCORE)))) begin
                     state_d = ST_OVER;
                  end else begin
                     state_d = ST_SERVE;
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end

         ST_OVER: begin
            ball_x_d = BALL_CX;
            ball_y_d = BALL_CY;
            if (bus.restart) begin
               score_l_d = 4'd0;
               score_r_d = 4'd0;
               l_pad_d   = PAD_C;
               r_pad_d   = PAD_C;
               cnt_d     = {CNT_W{1'b0}};
               state_d   = ST_SERVE;
            end else begin
               state_d = ST_OVER;
            end
         end

         default: begin
            state_d = ST_SERVE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase

`ifdef PONG_SPEEDUP_EN
      if (state_d == ST_SERVE && state_q != ST_SERVE) begin
         spd_x_d = SPD_W'(BALL_SPEED);
         spd_y_d = SPD_W'(BALL_SPEED);
      end else if (paddle_hit) begin
         spd_x_d = (spd_x_q < SPD_MAX) ? spd_x_q + SPD_W'(1) : SPD_MAX;
         spd_y_d = (spd_y_q < SPD_MAX) ? spd_y_q + SPD_W'(1) : SPD_MAX;
      end else begin
         spd_x_d = spd_x_q;
         spd_y_d = spd_y_q;
      end
`endif
   end

   // Game state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_SERVE;
         cnt_q     <= {CNT_W{1'b0}};
         ball_x_q  <= BALL_CX;
         ball_y_q  <= BALL_CY;
         l_pad_q   <= PAD_C;
         r_pad_q   <= PAD_C;
         score_l_q <= 4'd0;
         score_r_q <= 4'd0;
         dir_x_q   <= 1'b1;
         dir_y_q   <= 1'b1;
`ifdef PONG_SPEEDUP_EN
         spd_x_q   <= SPD_W'(BALL_SPEED);
         spd_y_q   <= SPD_W'(BALL_SPEED);
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ball_x_q  <= ball_x_d;
         ball_y_q  <= ball_y_d;
         l_pad_q   <= l_pad_d;
         r_pad_q   <= r_pad_d;
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
         dir_x_q   <= dir_x_d;
         dir_y_q   <= dir_y_d;
`ifdef PONG_SPEEDUP_EN
         spd_x_q   <= spd_x_d;
         spd_y_q   <= spd_y_d;
`endif
      end
   end

   assign bus.ball_x     = ball_x_q;
   assign bus.ball_y     = ball_y_q;
   assign bus.l_paddle_y = l_pad_q;
   assign bus.r_paddle_y = r_pad_q;
   assign bus.score_l    = score_l_q;
   assign bus.score_r    = score_r_q;
   assign bus.game_state = state_q;

endmodule

// File: tb/tb_pong_game_engine.sv
// Directed bench for pong_game_engine (WIN_SCORE=3): plays four full rallies with
// hand-traced ball trajectories, then game-over, restart and reset priority.
module tb_pong_game_engine;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #20 clk = ~clk;

   pong_game_engine_if bus_if ();

   pong_game_engine #(.WIN_SCORE(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_ball(input string tag, input int x, input int y);
      check_val({tag, "_x"}, int'(bus_if.ball_x), x);
      check_val({tag, "_y"}, int'(bus_if.ball_y), y);
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus_if.frame_tick = 1'b1;
         @(negedge clk);
         bus_if.frame_tick = 1'b0;
      end
   endtask

   initial begin
      bus_if.frame_tick = 1'b0;
      bus_if.l_up       = 1'b0;
      bus_if.l_down     = 1'b0;
      bus_if.r_up       = 1'b0;
      bus_if.r_down     = 1'b0;
      bus_if.restart    = 1'b0;
      rst_n             = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check_ball("rst_ball", 316, 236);
      check_val("rst_lpad", int'(bus_if.l_paddle_y), 210);
      check_val("rst_rpad", int'(bus_if.r_paddle_y), 210);
      check_val("rst_score_l", int'(bus_if.score_l), 0);
      check_val("rst_score_r", int'(bus_if.score_r), 0);
      check_val("rst_state", int'(bus_if.game_state), 0);

      // Serve with paddles driven to their limits
      bus_if.l_up   = 1'b1;
      bus_if.r_down = 1'b1;
      tick_n(52);
      check_val("lpad_52", int'(bus_if.l_paddle_y), 2);
      check_val("rpad_52", int'(bus_if.r_paddle_y), 418);
      tick_n(1);
      check_val("lpad_53", int'(bus_if.l_paddle_y), 0);
      check_val("rpad_53", int'(bus_if.r_paddle_y), 420);
      tick_n(6);
      check_val("serve_59_state", int'(bus_if.game_state), 0);
      check_ball("serve_59_ball", 316, 236);
      tick_n(1);
      check_val("serve_60_state", int'(bus_if.game_state), 1);
      check_val("lpad_60", int'(bus_if.l_paddle_y), 0);
      check_val("rpad_60", int'(bus_if.r_paddle_y), 420);
      bus_if.l_up   = 1'b0;
      bus_if.r_down = 1'b0;

      // Rally 1: bottom bounce, right catch, left miss
      tick_n(1);
      check_ball("r1_k1", 320, 240);
      repeat (1000) @(negedge clk);
      check_ball("idle_ball", 320, 240);
      check_val("idle_state", int'(bus_if.game_state), 1);
      tick_n(56);
      check_ball("r1_k57", 544, 464);
      tick_n(1);
      check_ball("r1_k58", 548, 468);
      tick_n(1);
      check_ball("r1_k59", 552, 472);
      tick_n(1);
      check_ball("r1_k60", 556, 468);
      tick_n(12);
      check_ball("r1_rcatch", 602, 420);
      tick_n(1);
      check_ball("r1_k73", 598, 416);
      tick_n(143);
      check_val("r1_lmiss_x", int'(bus_if.ball_x), 26);
      tick_n(7);
      check_val("r1_score_r", int'(bus_if.score_r), 1);
      check_val("r1_score_l", int'(bus_if.score_l), 0);
      check_val("r1_state", int'(bus_if.game_state), 0);
      check_ball("r1_recentre", 316, 236);

      // Rally 2: served left (left conceded), straight miss
      tick_n(60);
      check_val("r2_state", int'(bus_if.game_state), 1);
      tick_n(1);
      check_ball("r2_k1", 312, 240);
      tick_n(79);
      check_val("r2_score_r", int'(bus_if.score_r), 2);
      check_val("r2_state", int'(bus_if.game_state), 0);

      // Rally 3: top bounce, left catch, right miss
      tick_n(60);
      tick_n(72);
      check_ball("r3_lcatch", 30, 52);
      tick_n(1);
      check_ball("r3_k73", 34, 56);
      tick_n(143);
      check_val("r3_rmiss_x", int'(bus_if.ball_x), 606);
      tick_n(7);
      check_val("r3_score_l", int'(bus_if.score_l), 1);
      check_val("r3_score_r", int'(bus_if.score_r), 2);
      check_val("r3_state", int'(bus_if.game_state), 0);
      check_ball("r3_recentre", 316, 236);

      // Rally 4: served right, right paddle moved to top, winning miss on left
      bus_if.r_up = 1'b1;
      tick_n(60);
      check_val("r4_rpad_serve", int'(bus_if.r_paddle_y), 180);
      tick_n(1);
      check_ball("r4_k1", 320, 232);
      tick_n(44);
      check_val("r4_rpad_top", int'(bus_if.r_paddle_y), 0);
      tick_n(27);
      check_ball("r4_rcatch", 602, 52);
      tick_n(151);
      check_val("r4_score_r", int'(bus_if.score_r), 3);
      check_val("r4_state", int'(bus_if.game_state), 2);
      check_ball("r4_centre", 316, 236);

      // Game over ignores ticks and buttons
      bus_if.r_up   = 1'b0;
      bus_if.l_down = 1'b1;
      tick_n(5);
      check_val("go_state", int'(bus_if.game_state), 2);
      check_val("go_lpad", int'(bus_if.l_paddle_y), 0);
      check_val("go_rpad", int'(bus_if.r_paddle_y), 0);
      check_val("go_score_r", int'(bus_if.score_r), 3);
      @(negedge clk);
      bus_if.restart = 1'b1;
      @(negedge clk);
      bus_if.restart = 1'b0;
      check_val("rs_score_l", int'(bus_if.score_l), 0);
      check_val("rs_score_r", int'(bus_if.score_r), 0);
      check_val("rs_lpad", int'(bus_if.l_paddle_y), 210);
      check_val("rs_rpad", int'(bus_if.r_paddle_y), 210);
      check_val("rs_state", int'(bus_if.game_state), 0);

      // Reset wins over a concurrent frame tick
      tick_n(3);
      check_val("pre_rst_lpad", int'(bus_if.l_paddle_y), 222);
      @(negedge clk);
      rst_n             = 1'b0;
      bus_if.frame_tick = 1'b1;
      @(negedge clk);
      rst_n             = 1'b1;
      bus_if.frame_tick = 1'b0;
      check_val("rst_tick_lpad", int'(bus_if.l_paddle_y), 210);
      check_val("rst_tick_state", int'(bus_if.game_state), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
